// File: rtl/display_sequencer.sv
// Button-driven display sequencer: counts while running, requests a BCD conversion on a
// debounced press, then pages the eleven-digit result three digits at a time until the next press.
module display_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PAGE_CYCLES     = 25000000
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        toggle_btn,
  input  logic        conv_done,
  input  logic [43:0] bcd_in,
  output logic        count_en,
  output logic        conv_start,
  output logic [11:0] disp_digits,
  output logic [2:0]  disp_page,
  output logic [1:0]  state
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PG_W = $clog2(PAGE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PG_W-1:0] PG_LAST = PG_W'(PAGE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHOW    = 2'd2
  } state_t;

  logic            sync_p0, sync_p1;
  logic            db_level, db_prev;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  state_t          state_q, state_nxt;
  logic [43:0]     snap_q, snap_nxt;
  logic [1:0]      page_q, page_nxt;
  logic [PG_W-1:0] pcnt_q, pcnt_nxt;

  logic            count_en_nxt, conv_start_nxt;
  logic [2:0]      disp_page_nxt;
  logic [11:0]     disp_digits_nxt;

  // Page 0 carries only two digits, so its top nibble is blank.
  function automatic logic [11:0] page_digits(input logic [43:0] snap, input logic [1:0] page);
    case (page)
      2'd0:    page_digits = {4'hF, snap[43:36]};
      2'd1:    page_digits = snap[35:24];
      2'd2:    page_digits = snap[23:12];
      default: page_digits = snap[11:0];
    endcase
  endfunction

  // Stage p0/p1: synchronizer, then debounce; any bounce back restarts the count.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync_p0  <= 1'b1;
      sync_p1  <= 1'b1;
      db_level <= 1'b1;
      db_prev  <= 1'b1;
      db_cnt   <= '0;
    end else begin
      sync_p0 <= toggle_btn;
      sync_p1 <= sync_p0;
      db_prev <= db_level;
      if (sync_p1 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync_p1;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign press = db_prev & ~db_level;

  // Stage p2: FSM state, snapshot/page datapath and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q     <= ST_RUN;
      snap_q      <= '0;
      page_q      <= '0;
      pcnt_q      <= '0;
      count_en    <= 1'b1;
      conv_start  <= 1'b0;
      disp_page   <= 3'd4;
      disp_digits <= 12'hFFF;
    end else begin
      state_q     <= state_nxt;
      snap_q      <= snap_nxt;
      page_q      <= page_nxt;
      pcnt_q      <= pcnt_nxt;
      count_en    <= count_en_nxt;
      conv_start  <= conv_start_nxt;
      disp_page   <= disp_page_nxt;
      disp_digits <= disp_digits_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    snap_nxt  = snap_q;
    page_nxt  = page_q;
    pcnt_nxt  = pcnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (press) state_nxt = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (conv_done) begin
          state_nxt = ST_SHOW;
          snap_nxt  = bcd_in;
          page_nxt  = 2'd0;
          pcnt_nxt  = '0;
        end
      end
      ST_SHOW: begin
        // A press wins over a simultaneous page expiry.
        if (press) begin
          state_nxt = ST_RUN;
          pcnt_nxt  = '0;
        end else if (pcnt_q == PG_LAST) begin
          page_nxt = page_q + 2'd1;
          pcnt_nxt = '0;
        end else begin
          pcnt_nxt = pcnt_q + PG_W'(1);
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  always_comb begin
    count_en_nxt    = (state_nxt == ST_RUN);
    conv_start_nxt  = (state_q == ST_RUN) && (state_nxt == ST_CONVERT);
    disp_page_nxt   = 3'd4;
    disp_digits_nxt = 12'hFFF;
    if (state_nxt == ST_SHOW) begin
      disp_page_nxt   = {1'b0, page_nxt};
      disp_digits_nxt = page_digits(snap_nxt, page_nxt);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Bench for display_sequencer: vector table, directed paging/press/reset sequences and a
// randomized run checked every cycle against a window-based behavioural model.
module tb_display_sequencer;

  localparam int DB = 4;
  localparam int PG = 8;

  logic        CLOCK_50;
  logic        rst;
  logic        toggle_btn;
  logic        conv_done;
  logic [43:0] bcd_in;
  logic        count_en;
  logic        conv_start;
  logic [11:0] disp_digits;
  logic [2:0]  disp_page;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  display_sequencer #(.DEBOUNCE_CYCLES(DB), .PAGE_CYCLES(PG)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .toggle_btn (toggle_btn),
    .conv_done  (conv_done),
    .bcd_in     (bcd_in),
    .count_en   (count_en),
    .conv_start (conv_start),
    .disp_digits(disp_digits),
    .disp_page  (disp_page),
    .state      (state)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: raw samples pass a 2-deep delay, the debounced level flips when the
  // last DB synchronized samples all differ from it, and the page is elapsed-time / PG mod 4.
  bit          m_valid = 0;
  bit          m_s0, m_s1, m_db, m_fall;
  bit          win[$];
  int          m_mode, m_show_t;
  logic [43:0] m_snap;
  logic [1:0]  e_state;
  logic        e_ce, e_cs;
  logic [2:0]  e_pg;
  logic [11:0] e_dg;

  function automatic logic [3:0] m_digit(input logic [43:0] s, input int i);
    if (i > 10) return 4'hF;
    return 4'((s >> (4 * i)) & 44'hF);
  endfunction

  task automatic model_step();
    bit press, s_used, all_diff;
    if (rst) begin
      m_valid = 1;
      m_s0 = 1; m_s1 = 1; m_db = 1; m_fall = 0;
      win.delete();
      m_mode = 0; m_show_t = 0; m_snap = '0;
      e_state = 2'd0; e_ce = 1; e_cs = 0; e_pg = 3'd4; e_dg = 12'hFFF;
      return;
    end
    press  = m_fall;
    m_fall = 0;
    s_used = m_s1;
    win.push_back(s_used);
    if (win.size() > DB) void'(win.pop_front());
    all_diff = (win.size() == DB);
    foreach (win[i]) if (win[i] == m_db) all_diff = 0;
    if (all_diff) begin
      m_db = s_used;
      if (!m_db) m_fall = 1;
    end
    m_s1 = m_s0;
    m_s0 = toggle_btn;
    e_cs = 0;
    case (m_mode)
      0: if (press) begin m_mode = 1; e_cs = 1; end
      1: if (conv_done) begin m_mode = 2; m_snap = bcd_in; m_show_t = 0; end
      default: if (press) m_mode = 0; else m_show_t++;
    endcase
    e_state = 2'(m_mode);
    e_ce    = (m_mode == 0);
    if (m_mode == 2) begin
      int p;
      p    = (m_show_t / PG) % 4;
      e_pg = 3'(p);
      e_dg = {m_digit(m_snap, 11 - 3 * p), m_digit(m_snap, 10 - 3 * p), m_digit(m_snap, 9 - 3 * p)};
    end else begin
      e_pg = 3'd4;
      e_dg = 12'hFFF;
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    #1;
    if (m_valid) begin
      chk("mdl_state", 64'(state), 64'(e_state));
      chk("mdl_count_en", 64'(count_en), 64'(e_ce));
      chk("mdl_conv_start", 64'(conv_start), 64'(e_cs));
      chk("mdl_disp_page", 64'(disp_page), 64'(e_pg));
      chk("mdl_disp_digits", 64'(disp_digits), 64'(e_dg));
    end
  endtask

  typedef struct {
    logic        rst;
    logic        btn;
    logic [1:0]  st;
    logic        ce;
    logic        cs;
    logic [2:0]  pg;
    logic [11:0] dg;
  } vec_t;

  vec_t        vecs[12];
  logic [11:0] pages[4];

  initial begin
    logic [63:0] r64;
    int hold;

    rst = 0; toggle_btn = 1; conv_done = 0; bcd_in = '0;
    pages[0] = 12'hF12; pages[1] = 12'h345; pages[2] = 12'h678; pages[3] = 12'h901;

    // Reset, then ten low cycles: one conv_start on the 7th low sample.
    vecs[0] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 3'd4, 12'hFFF};
    for (int i = 1; i <= 6; i++) vecs[i] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd4, 12'hFFF};
    vecs[7] = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 3'd4, 12'hFFF};
    for (int i = 8; i <= 10; i++) vecs[i] = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 3'd4, 12'hFFF};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 3'd4, 12'hFFF};

    repeat (2) tick();
    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst;
      toggle_btn = vecs[i].btn;
      tick();
      chk("tbl_state", 64'(state), 64'(vecs[i].st));
      chk("tbl_count_en", 64'(count_en), 64'(vecs[i].ce));
      chk("tbl_conv_start", 64'(conv_start), 64'(vecs[i].cs));
      chk("tbl_disp_page", 64'(disp_page), 64'(vecs[i].pg));
      chk("tbl_disp_digits", 64'(disp_digits), 64'(vecs[i].dg));
    end
    rst = 0;

    // Conversion result paged three digits at a time, eight cycles per page.
    repeat (8) tick();
    chk("convert_hold", 64'(state), 64'd1);
    bcd_in = 44'h123_4567_8901;
    conv_done = 1;
    tick();
    conv_done = 0;
    chk("show_state", 64'(state), 64'd2);
    chk("show_page0", 64'(disp_page), 64'd0);
    chk("show_digits0", 64'(disp_digits), 64'(pages[0]));
    for (int p = 1; p <= 4; p++) begin
      repeat (7) tick();
      chk("page_hold", 64'(disp_page), 64'((p - 1) % 4));
      tick();
      chk("page_adv", 64'(disp_page), 64'(p % 4));
      chk("page_digits", 64'(disp_digits), 64'(pages[p % 4]));
    end

    // Press whose event lands on the page-expiry edge.
    tick();
    toggle_btn = 0;
    repeat (6) tick();
    chk("coinc_pre_state", 64'(state), 64'd2);
    chk("coinc_pre_page", 64'(disp_page), 64'd0);
    tick();
    chk("coinc_state", 64'(state), 64'd0);
    chk("coinc_count_en", 64'(count_en), 64'd1);
    chk("coinc_page", 64'(disp_page), 64'd4);
    chk("coinc_digits", 64'(disp_digits), 64'hFFF);
    toggle_btn = 1;
    repeat (10) tick();

    // Short press and glitchy press must both be rejected.
    toggle_btn = 0;
    repeat (3) tick();
    toggle_btn = 1;
    repeat (8) begin
      tick();
      chk("short_press_state", 64'(state), 64'd0);
    end
    for (int i = 0; i < 6; i++) begin
      toggle_btn = (i == 2);
      tick();
    end
    toggle_btn = 1;
    repeat (8) begin
      tick();
      chk("glitch_state", 64'(state), 64'd0);
      chk("glitch_conv_start", 64'(conv_start), 64'd0);
    end

    // conv_done while running is ignored.
    bcd_in = 44'h999_8887_7766;
    conv_done = 1;
    tick();
    conv_done = 0;
    tick();
    chk("run_done_state", 64'(state), 64'd0);
    chk("run_done_snap", 64'(dut.snap_q), 64'h123_4567_8901);

    // Reset aborts a conversion; a late conv_done is ignored.
    toggle_btn = 0;
    repeat (8) tick();
    chk("abort_in_convert", 64'(state), 64'd1);
    toggle_btn = 1;
    repeat (8) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_rst_state", 64'(state), 64'd0);
    bcd_in = 44'h555_4443_3322;
    conv_done = 1;
    tick();
    conv_done = 0;
    tick();
    chk("abort_state", 64'(state), 64'd0);
    chk("abort_count_en", 64'(count_en), 64'd1);
    chk("abort_page", 64'(disp_page), 64'd4);
    chk("abort_digits", 64'(disp_digits), 64'hFFF);
    chk("abort_snap", 64'(dut.snap_q), 64'd0);

    // Randomized traffic against the model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        toggle_btn = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      conv_done = ($urandom_range(0, 7) == 0);
      r64 = {$urandom, $urandom};
      bcd_in = r64[43:0];
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 0;
    conv_done = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
